// File: rtl/sad_if.sv
// sad_if: sample-in / result-out bundle for the SAD accumulator.
// The upstream/consumer side uses the master modport, the accumulator uses slave.
interface sad_if #(
   parameter int N       = 8,
   parameter int COUNT_W = 4
);
   // Sample side
   logic                   in_valid;
   logic                   in_ready;
   logic [N-1:0]           diff;
   logic                   borrow;
   logic [COUNT_W-1:0]     len;
   logic                   flush;
   // Result side
   logic                   out_valid;
   logic                   out_ready;
   logic [N+COUNT_W-1:0]   sad;
   logic [COUNT_W:0]       neg_count;

   modport master (
      output in_valid, diff, borrow, len, flush, out_ready,
      input  in_ready, out_valid, sad, neg_count
   );

   modport slave (
      input  in_valid, diff, borrow, len, flush, out_ready,
      output in_ready, out_valid, sad, neg_count
   );
endinterface

// File: rtl/sad_accumulator.sv
// sad_accumulator: sums |A-B| magnitudes and counts negative differences over
// a block of programmable length, then holds the totals on a valid/ready port
// until the consumer takes them.
module sad_accumulator #(
   parameter int N       = 8,
   parameter int COUNT_W = 4
) (
   input  logic  clk,
   input  logic  rst,
   sad_if.slave  bus_io
);
   // The sum of 2^COUNT_W samples of at most 2^N-1 always fits in N+COUNT_W bits.
   localparam int ACC_W = N + COUNT_W;
   localparam int CNT_W = COUNT_W + 1;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{COUNT_W{1'b0}}, 1'b1};
   // len==0 encodes a full block of 2^COUNT_W samples.
   localparam logic [CNT_W-1:0] CNT_FULL = {1'b1, {COUNT_W{1'b0}}};
   localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ACCUM = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   state_t             state_q,  state_d;
   logic [ACC_W-1:0]   acc_q,    acc_d;
   logic [CNT_W-1:0]   neg_q,    neg_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [CNT_W-1:0]   target_q, target_d;
   logic [ACC_W-1:0]   sad_q,    sad_d;
   logic [CNT_W-1:0]   negcnt_q, negcnt_d;

   logic               in_ready_s;
   logic               in_accept_s;
   logic               out_accept_s;
   logic [ACC_W-1:0]   diff_ext_s;
   logic [CNT_W-1:0]   borrow_ext_s;
   logic [CNT_W-1:0]   len_target_s;
   logic [ACC_W-1:0]   acc_sum_s;
   logic [CNT_W-1:0]   neg_sum_s;
   logic [CNT_W-1:0]   cnt_inc_s;

   // Handshake decode: ready/valid come from the state register only.
   assign in_ready_s   = (state_q != ST_DONE);
   assign in_accept_s  = bus_io.in_valid & in_ready_s;
   assign out_accept_s = (state_q == ST_DONE) & bus_io.out_ready;

   // Operand extension and the per-sample running sums.
   assign diff_ext_s   = {{COUNT_W{1'b0}}, bus_io.diff};
   assign borrow_ext_s = {{COUNT_W{1'b0}}, bus_io.borrow};
   assign len_target_s = (bus_io.len == {COUNT_W{1'b0}}) ? CNT_FULL
                                                         : {1'b0, bus_io.len};
   assign acc_sum_s    = acc_q + diff_ext_s;
   assign neg_sum_s    = neg_q + borrow_ext_s;
   assign cnt_inc_s    = cnt_q + CNT_ONE;

   // Next-state and datapath update for the IDLE/ACCUM/DONE block sequencer.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      cnt_d    = cnt_q;
      target_d = target_q;
      sad_d    = sad_q;
      negcnt_d = negcnt_q;

      case (state_q)
         ST_IDLE: begin
            // flush is meaningless here; a same-cycle sample starts a block.
            if (in_accept_s) begin
               target_d = len_target_s;
               acc_d    = diff_ext_s;
               neg_d    = borrow_ext_s;
               cnt_d    = CNT_ONE;
               if (len_target_s == CNT_ONE) begin
                  state_d  = ST_DONE;
                  sad_d    = diff_ext_s;
                  negcnt_d = borrow_ext_s;
               end else begin
                  state_d  = ST_ACCUM;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_ACCUM: begin
            // flush beats a simultaneous sample: the partial block is thrown away.
            if (bus_io.flush) begin
               state_d = ST_IDLE;
               acc_d   = ACC_ZERO;
               neg_d   = CNT_ZERO;
               cnt_d   = CNT_ZERO;
            end else if (in_accept_s) begin
               acc_d = acc_sum_s;
               neg_d = neg_sum_s;
               cnt_d = cnt_inc_s;
               if (cnt_inc_s == target_q) begin
                  state_d  = ST_DONE;
                  sad_d    = acc_sum_s;
                  negcnt_d = neg_sum_s;
               end else begin
                  state_d  = ST_ACCUM;
               end
            end else begin
               state_d = ST_ACCUM;
            end
         end

         ST_DONE: begin
            // Result is held until taken; flush never discards it.
            if (out_accept_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            acc_d   = ACC_ZERO;
            neg_d   = CNT_ZERO;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // State and datapath registers; reset clears everything without a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         acc_q    <= ACC_ZERO;
         neg_q    <= CNT_ZERO;
         cnt_q    <= CNT_ZERO;
         target_q <= CNT_ZERO;
         sad_q    <= ACC_ZERO;
         negcnt_q <= CNT_ZERO;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         cnt_q    <= cnt_d;
         target_q <= target_d;
         sad_q    <= sad_d;
         negcnt_q <= negcnt_d;
      end
   end

   assign bus_io.in_ready  = in_ready_s;
   assign bus_io.out_valid = (state_q == ST_DONE);
   assign bus_io.sad       = sad_q;
   assign bus_io.neg_count = negcnt_q;

endmodule
